// File: rtl/fetch_stage.sv
// Instruction fetch stage: a PC register drives instruction memory, and each
// fetched {pc, instr} pair is held in a two-entry buffer that feeds decode
// through a valid/ready handshake. A redirect flushes the buffer and reloads the
// PC. Reset is asynchronous and active-high.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no fetches issued, PC frozen; buffered entries still drain
// FETCH | one fetch per cycle while the buffer has room (or frees a slot)
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_1000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc4,
    output logic        misaligned
);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    localparam logic [1:0] FULL_COUNT = BUF_DEPTH[1:0];

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [1:0]  count;
    logic        head;
    logic        tail;
    logic        pop;
    logic        capture;
    logic        misaligned_q;
    logic [31:0] buf_pc    [2];
    logic [31:0] buf_instr [2];

    // Handshake and capture decisions; a full buffer may still capture when
    // the head leaves in the same cycle, since the freed slot is the tail.
    always_comb begin
        pop     = (count != 2'd0) && out_ready;
        capture = (state == FETCH) && !redirect_valid &&
                  ((count != FULL_COUNT) || pop);
        tail    = head ^ count[0];
    end

    // Next-state logic for the fetch enable FSM.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fetch_en)  state_nxt = FETCH;
            FETCH:   if (!fetch_en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // PC, occupancy, head pointer and sticky misalignment flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc           <= RESET_PC;
            count        <= 2'd0;
            head         <= 1'b0;
            misaligned_q <= 1'b0;
        end else if (redirect_valid) begin
            pc    <= {redirect_pc[31:2], 2'b00};
            count <= 2'd0;
            head  <= 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
                misaligned_q <= 1'b1;
            end
        end else begin
            if (capture) begin
                pc <= pc + 32'd4;
            end
            if (pop) begin
                head <= ~head;
            end
            case ({capture, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Buffer payload; contents are only meaningful behind a nonzero count,
    // so the storage itself needs no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            buf_pc[tail]    <= pc;
            buf_instr[tail] <= imem_rd;
        end
    end

    // Output presentation from the buffer head.
    always_comb begin
        imem_addr  = pc;
        out_valid  = (count != 2'd0);
        out_pc     = buf_pc[head];
        out_instr  = buf_instr[head];
        out_pc4    = buf_pc[head] + 32'd4;
        misaligned = misaligned_q;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stimulus pushes hand-computed deliveries
// into a queue, a negedge monitor pops and compares on every handshake.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic        misaligned;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   delivered   = 0;

    logic        prev_stall    = 1'b0;
    logic        prev_redirect = 1'b0;
    logic [31:0] prev_pc       = '0;
    logic [31:0] prev_instr    = '0;

    fetch_stage #(
        .RESET_PC (32'h0000_1000),
        .BUF_DEPTH(2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_en      (fetch_en),
        .imem_addr     (imem_addr),
        .imem_rd       (imem_rd),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_pc4       (out_pc4),
        .misaligned    (misaligned)
    );

    always #5 clk = ~clk;

    // Instruction memory: three known words, otherwise the inverted address.
    always_comb begin
        case (imem_addr)
            32'h0000_1000: imem_rd = 32'hFFC4_A303;
            32'h0000_1004: imem_rd = 32'h0064_A423;
            32'h0000_1008: imem_rd = 32'h0062_E233;
            default:       imem_rd = ~imem_addr;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] pc4);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        e.pc4   = pc4;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        fetch_en       = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        tick();
        rst = 1'b0;
    endtask

    // Monitor: compare every handshake against the queue head, and check
    // that a stalled head stays put unless a redirect or reset intervened.
    always @(negedge clk) begin
        if (rst === 1'b0 && prev_stall && !prev_redirect) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_pc", out_pc, prev_pc);
            chk("hold_instr", out_instr, prev_instr);
        end
        if (out_valid && out_ready && rst === 1'b0) begin
            delivered++;
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_delivery: got pc %h expected none", out_pc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_pc", out_pc, e.pc);
                chk("sb_instr", out_instr, e.instr);
                chk("sb_pc4", out_pc4, e.pc4);
            end
        end
        prev_stall    = out_valid && !out_ready && (rst === 1'b0);
        prev_redirect = redirect_valid;
        prev_pc       = out_pc;
        prev_instr    = out_instr;
    end

    initial begin
        int start_cnt;

        // Reset state, checked before any clock edge.
        rst            = 1'b1;
        fetch_en       = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #2;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'h0000_1000);
        chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
        tick();
        tick();

        // Streaming at one per cycle.
        rst       = 1'b0;
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        push(32'h0000_1000, 32'hFFC4_A303, 32'h0000_1004);
        push(32'h0000_1004, 32'h0064_A423, 32'h0000_1008);
        push(32'h0000_1008, 32'h0062_E233, 32'h0000_100C);
        start_cnt = delivered;
        repeat (5) tick();
        out_ready = 1'b0;
        chk("stream_count", delivered - start_cnt, 3);
        chk("stream_sb_empty", sb_q.size(), 0);

        // Back-pressure: buffer fills, PC holds, then drains in order.
        do_reset();
        fetch_en = 1'b1;
        repeat (5) tick();
        chk("bp_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_pc", out_pc, 32'h0000_1000);
        chk("bp_instr", out_instr, 32'hFFC4_A303);
        chk("bp_pc4", out_pc4, 32'h0000_1004);
        chk("bp_imem_addr", imem_addr, 32'h0000_1008);
        push(32'h0000_1000, 32'hFFC4_A303, 32'h0000_1004);
        push(32'h0000_1004, 32'h0064_A423, 32'h0000_1008);
        push(32'h0000_1008, 32'h0062_E233, 32'h0000_100C);
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
        chk("bp_sb_empty", sb_q.size(), 0);

        // Redirect with two entries buffered and PC at 0x100C.
        do_reset();
        fetch_en = 1'b1;
        repeat (3) tick();
        push(32'h0000_1000, 32'hFFC4_A303, 32'h0000_1004);
        out_ready = 1'b1;
        tick();
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_1000;
        chk("pre_redir_imem_addr", imem_addr, 32'h0000_100C);
        chk("pre_redir_valid", {31'd0, out_valid}, 32'd1);
        tick();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        chk("redir_flush_valid", {31'd0, out_valid}, 32'd0);
        chk("redir_imem_addr", imem_addr, 32'h0000_1000);
        push(32'h0000_1000, 32'hFFC4_A303, 32'h0000_1004);
        repeat (2) tick();
        out_ready = 1'b0;
        chk("redir_sb_empty", sb_q.size(), 0);

        // Misaligned redirect, then an aligned one to the top of memory.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2002;
        tick();
        chk("mis_imem_addr", imem_addr, 32'h0000_2000);
        chk("mis_flag", {31'd0, misaligned}, 32'd1);
        chk("mis_flush_valid", {31'd0, out_valid}, 32'd0);
        redirect_pc = 32'hFFFF_FFFC;
        out_ready   = 1'b1;
        tick();
        redirect_valid = 1'b0;
        chk("wrap_imem_addr", imem_addr, 32'hFFFF_FFFC);
        chk("mis_sticky", {31'd0, misaligned}, 32'd1);
        push(32'hFFFF_FFFC, 32'h0000_0003, 32'h0000_0000);
        push(32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0004);
        repeat (3) tick();
        out_ready = 1'b0;
        chk("wrap_sb_empty", sb_q.size(), 0);

        // Asynchronous reset between edges with the buffer full.
        tick();
        chk("pre_arst_valid", {31'd0, out_valid}, 32'd1);
        chk("pre_arst_pc", out_pc, 32'h0000_0004);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_imem_addr", imem_addr, 32'h0000_1000);
        chk("arst_misaligned", {31'd0, misaligned}, 32'd0);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        push(32'h0000_1000, 32'hFFC4_A303, 32'h0000_1004);
        repeat (3) tick();
        out_ready = 1'b0;
        fetch_en  = 1'b0;
        repeat (2) tick();
        chk("arst_sb_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_1000, the first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, the fetch-buffer entries (fixed at 2 in this revision).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port fetch_en  input  1  permits new fetches when 1.
REQ-006 SHALL have port imem_addr  output  32  byte address to instruction memory; equals the PC register.
REQ-007 SHALL have port imem_rd  input  32  instruction word, combinationally valid for imem_addr in the same cycle.
REQ-008 SHALL have port redirect_valid  input  1  branch/jump taken; overrides sequential fetch.
REQ-009 SHALL have port redirect_pc  input  32  target address for a redirect.
REQ-010 SHALL have port out_valid  output  1  buffer head holds a valid instruction.
REQ-011 SHALL have port out_ready  input  1  downstream decode accepts the head this cycle.
REQ-012 SHALL have port out_instr  output  32  instruction at the buffer head.
REQ-013 SHALL have port out_pc  output  32  address of out_instr.
REQ-014 SHALL have port out_pc4  output  32  out_pc + 4, modulo 2^32.
REQ-015 SHALL have port misaligned  output  1  sticky flag: a redirect target had nonzero bits [1:0].

Function
REQ-016 SHALL implement FSM states IDLE and FETCH; IDLE after reset; IDLE->FETCH on the first edge with fetch_en=1; FETCH->IDLE when fetch_en=0 at an edge.
REQ-017 SHALL capture {PC, imem_rd} into the buffer tail and set PC<=PC+4 in any FETCH cycle with redirect_valid=0 and the buffer not full, or full with a pop this same cycle.
REQ-018 SHALL not capture or advance the PC in IDLE; already-buffered entries remain drainable.
REQ-019 SHALL pop the head when out_valid=1 and out_ready=1; out_valid SHALL equal (count != 0).
REQ-020 SHALL, on redirect_valid=1 in any state, flush all buffer entries (count<=0), set PC<=redirect_pc with bits [1:0] forced to 0, and capture nothing that cycle.
REQ-021 SHALL drive out_valid=0 in the cycle after a redirect edge, whatever the out_ready value of the redirect cycle.
REQ-022 SHALL set misaligned<=1 on a redirect with redirect_pc[1:0]!=0; it clears only on reset.
REQ-023 SHALL hold out_instr, out_pc and out_pc4 stable while out_valid=1 and out_ready=0.
REQ-024 SHALL wrap the PC from 32'hFFFF_FFFC to 32'h0000_0000 without a flag.
REQ-025 SHALL, with the buffer full and no pop, hold the PC and capture nothing (back-pressure).
REQ-026 SHALL give one-cycle fetch latency: an instruction captured at edge N is presented with out_valid=1 after edge N.
REQ-027 SHALL sustain one instruction per cycle when out_ready stays 1.

Reset
REQ-028 SHALL, while rst=1 and independent of clk, set PC=RESET_PC, state=IDLE, buffer count=0, out_valid=0, misaligned=0.
REQ-029 SHALL drive imem_addr=RESET_PC during reset; out_instr/out_pc contents are don't-care while out_valid=0.
REQ-030 SHALL, on rst asserted mid-operation, discard all buffered entries immediately, with no pop reaching downstream.

Verification
REQ-031 Release reset, fetch_en=1, out_ready=1, imem returns FFC4A303, 0064A423, 0062E233 -> out_pc sequence 0x1000, 0x1004, 0x1008 on consecutive cycles with matching out_instr; out_pc4=0x1004 with the first entry.
REQ-032 Hold out_ready=0 for 5 cycles -> count reaches 2, PC holds at 0x1008, out_pc stays 0x1000; then out_ready=1 -> 0x1000, 0x1004, 0x1008 delivered in order with none lost or duplicated.
REQ-033 At PC=0x100C, redirect_valid=1, redirect_pc=0x1000, both entries buffered -> next cycle out_valid=0, imem_addr=0x1000; the next delivered out_pc is 0x1000.
REQ-034 Redirect to 0x2002 -> PC=0x2000, misaligned=1 and stays 1 through later redirects until rst.
REQ-035 Redirect to 0xFFFF_FFFC with out_ready=1 -> delivered out_pc sequence 0xFFFF_FFFC, 0x0000_0000; out_pc4 of the first = 0x0000_0000.
REQ-036 Assert rst asynchronously between edges with 2 entries buffered -> out_valid falls before the next edge; after release, the first out_pc is 0x1000.
